// File: rtl/vera_bus_sequencer.sv
// VERA external register bus master: replays a ROM init script after start,
// then serves single-register runtime reads/writes with timed cs/strobe phases.
module vera_bus_sequencer #(
  parameter int ROM_AW     = 6,
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              init_done,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [13:0]       rom_data,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [4:0]        req_addr,
  input  logic [7:0]        req_wdata,
  output logic              rd_valid,
  output logic [7:0]        rd_data,
  output logic              extbus_cs_n,
  output logic              extbus_rd_n,
  output logic              extbus_wr_n,
  output logic [4:0]        extbus_a,
  output logic [7:0]        extbus_dout,
  output logic              extbus_doe,
  input  logic [7:0]        extbus_din
);
  localparam int MAX_SH = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
  localparam int MAXC   = (STROBE_CYC > MAX_SH) ? STROBE_CYC : MAX_SH;
  localparam int CW     = (MAXC < 2) ? 1 : $clog2(MAXC);

  localparam logic [CW-1:0]     SET_LD  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0]     STB_LD  = CW'(STROBE_CYC - 1);
  localparam logic [CW-1:0]     HLD_LD  = CW'(HOLD_CYC - 1);
  localparam logic [ROM_AW-1:0] ROM_TOP = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SETUP,
    S_STROBE,
    S_HOLD
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              last_q, last_d;
  logic              scr_q, scr_d;
  logic [4:0]        a_q, a_d;
  logic [7:0]        dout_q, dout_d;
  logic              doe_q, doe_d;
  logic              cs_n_q, cs_n_d;
  logic              rd_n_q, rd_n_d;
  logic              wr_n_q, wr_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  logic              rd_valid_q, rd_valid_d;
  logic [7:0]        rd_data_q, rd_data_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    last_d     = last_q;
    scr_d      = scr_q;
    a_d        = a_q;
    dout_d     = dout_q;
    doe_d      = doe_q;
    cs_n_d     = cs_n_q;
    rd_n_d     = rd_n_q;
    wr_n_d     = wr_n_q;
    busy_d     = busy_q;
    done_d     = done_q;
    rom_addr_d = rom_addr_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          rom_addr_d = '0;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          state_d    = S_FETCH;
        end else if (req_valid) begin
          we_d    = req_we;
          a_d     = req_addr;
          dout_d  = req_wdata;
          scr_d   = 1'b0;
          last_d  = 1'b0;
          doe_d   = req_we;
          cs_n_d  = 1'b0;
          cnt_d   = SET_LD;
          state_d = S_SETUP;
        end
      end
      S_FETCH: begin
        we_d    = 1'b1;
        a_d     = rom_data[12:8];
        dout_d  = rom_data[7:0];
        last_d  = rom_data[13];
        scr_d   = 1'b1;
        doe_d   = 1'b1;
        cs_n_d  = 1'b0;
        cnt_d   = SET_LD;
        state_d = S_SETUP;
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          rd_n_d  = we_q;
          wr_n_d  = ~we_q;
          cnt_d   = STB_LD;
          state_d = S_STROBE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_STROBE: begin
        if (cnt_q == '0) begin
          rd_n_d  = 1'b1;
          wr_n_d  = 1'b1;
          cnt_d   = HLD_LD;
          state_d = S_HOLD;
          if (!we_q) rd_data_d = extbus_din;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          cs_n_d     = 1'b1;
          doe_d      = 1'b0;
          rd_valid_d = ~we_q;
          state_d    = S_IDLE;
          // the top ROM address always ends the script; no wrap to 0
          if (scr_q && !last_q && rom_addr_q != ROM_TOP) begin
            rom_addr_d = rom_addr_q + 1'b1;
            state_d    = S_FETCH;
          end else if (scr_q) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      last_q     <= 1'b0;
      scr_q      <= 1'b0;
      a_q        <= '0;
      dout_q     <= '0;
      doe_q      <= 1'b0;
      cs_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rom_addr_q <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      last_q     <= last_d;
      scr_q      <= scr_d;
      a_q        <= a_d;
      dout_q     <= dout_d;
      doe_q      <= doe_d;
      cs_n_q     <= cs_n_d;
      rd_n_q     <= rd_n_d;
      wr_n_q     <= wr_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rom_addr_q <= rom_addr_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign req_ready   = (state_q == S_IDLE) & ~start;
  assign busy        = busy_q;
  assign init_done   = done_q;
  assign rom_addr    = rom_addr_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign extbus_cs_n = cs_n_q;
  assign extbus_rd_n = rd_n_q;
  assign extbus_wr_n = wr_n_q;
  assign extbus_a    = a_q;
  assign extbus_dout = dout_q;
  assign extbus_doe  = doe_q;

endmodule

// File: tb/tb_vera_bus_sequencer.sv
// Bench for vera_bus_sequencer: three instances (default, ROM_AW=3, slow timing)
// checked per cycle against a transaction-level model of the bus.
module tb_vera_bus_sequencer;
  typedef struct packed {
    logic       we;
    logic [4:0] a;
    logic [7:0] d;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  logic [2:0]  rst_v;
  logic [2:0]  start_v;
  logic        req_valid, req_we;
  logic [4:0]  req_addr;
  logic [7:0]  req_wdata;
  logic [7:0]  rd_val;
  logic [7:0]  din_v [3];
  logic [13:0] roms [3][64];

  wire [2:0] cs_n_v, rd_n_v, wr_n_v, doe_v, busy_v, done_v, rdv_v, rdy_v;
  wire [4:0] a_v [3];
  wire [7:0] dout_v [3];
  wire [7:0] rdd_v [3];
  wire [5:0] ra0;
  wire [2:0] ra1, ra2;
  // ROM word follows the registered address into the next cycle
  wire [13:0] rd0 = roms[0][ra0];
  wire [13:0] rd1 = roms[1][ra1];
  wire [13:0] rd2 = roms[2][ra2];

  vera_bus_sequencer u0 (
    .clk(clk), .reset(rst_v[0]), .start(start_v[0]),
    .busy(busy_v[0]), .init_done(done_v[0]),
    .rom_addr(ra0), .rom_data(rd0),
    .req_valid(req_valid), .req_ready(rdy_v[0]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rd_valid(rdv_v[0]), .rd_data(rdd_v[0]),
    .extbus_cs_n(cs_n_v[0]), .extbus_rd_n(rd_n_v[0]),
    .extbus_wr_n(wr_n_v[0]), .extbus_a(a_v[0]),
    .extbus_dout(dout_v[0]), .extbus_doe(doe_v[0]),
    .extbus_din(din_v[0])
  );

  vera_bus_sequencer #(.ROM_AW(3)) u1 (
    .clk(clk), .reset(rst_v[1]), .start(start_v[1]),
    .busy(busy_v[1]), .init_done(done_v[1]),
    .rom_addr(ra1), .rom_data(rd1),
    .req_valid(1'b0), .req_ready(rdy_v[1]), .req_we(1'b0),
    .req_addr(5'h00), .req_wdata(8'h00),
    .rd_valid(rdv_v[1]), .rd_data(rdd_v[1]),
    .extbus_cs_n(cs_n_v[1]), .extbus_rd_n(rd_n_v[1]),
    .extbus_wr_n(wr_n_v[1]), .extbus_a(a_v[1]),
    .extbus_dout(dout_v[1]), .extbus_doe(doe_v[1]),
    .extbus_din(din_v[1])
  );

  vera_bus_sequencer #(
    .ROM_AW(3), .SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(2)
  ) u2 (
    .clk(clk), .reset(rst_v[2]), .start(start_v[2]),
    .busy(busy_v[2]), .init_done(done_v[2]),
    .rom_addr(ra2), .rom_data(rd2),
    .req_valid(1'b0), .req_ready(rdy_v[2]), .req_we(1'b0),
    .req_addr(5'h00), .req_wdata(8'h00),
    .rd_valid(rdv_v[2]), .rd_data(rdd_v[2]),
    .extbus_cs_n(cs_n_v[2]), .extbus_rd_n(rd_n_v[2]),
    .extbus_wr_n(wr_n_v[2]), .extbus_a(a_v[2]),
    .extbus_dout(dout_v[2]), .extbus_doe(doe_v[2]),
    .extbus_din(din_v[2])
  );

  function automatic int sp(input int k); return (k == 2) ? 2 : 1; endfunction
  function automatic int tp(input int k); return (k == 2) ? 3 : 2; endfunction
  function automatic int hp(input int k); return (k == 2) ? 2 : 1; endfunction

  function automatic void chk(input string nm, input int k,
                              input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s[u%0d]: got %0h expected %0h at %0t", nm, k, got, exp, $time);
    end
  endfunction

  txn_t expq [3][128];
  int   qh [3], qt [3];
  int   len [3], nstb [3], first [3], lastl [3];
  int   acc_cnt [3], last_len [3], bcnt [3], bexp [3];
  logic in_acc [3], iswe [3], doe0 [3], unstable [3], pbusy [3];
  logic [4:0] a0 [3];
  logic [7:0] d0 [3];

  task automatic mon(input int k);
    txn_t e;
    logic rdv_exp;
    logic ok;
    if (rst_v[k]) begin
      in_acc[k] = 1'b0;
      pbusy[k]  = 1'b0;
      return;
    end
    ok = (rd_n_v[k] | wr_n_v[k]) &
         (~cs_n_v[k] | (rd_n_v[k] & wr_n_v[k] & ~doe_v[k]));
    chk("bus_inv", k, 32'(ok), 32'd1);
    rdv_exp = 1'b0;
    if (!cs_n_v[k]) begin
      if (!in_acc[k]) begin
        in_acc[k] = 1'b1; len[k] = 0; nstb[k] = 0; first[k] = 0; lastl[k] = 0;
        a0[k] = a_v[k]; d0[k] = dout_v[k]; doe0[k] = doe_v[k];
        unstable[k] = 1'b0; iswe[k] = 1'b0;
      end
      len[k]++;
      if (a_v[k] !== a0[k] || doe_v[k] !== doe0[k] ||
          (doe0[k] && dout_v[k] !== d0[k])) unstable[k] = 1'b1;
      if (!rd_n_v[k] || !wr_n_v[k]) begin
        nstb[k]++;
        if (first[k] == 0) first[k] = len[k];
        lastl[k] = len[k];
        iswe[k]  = ~wr_n_v[k];
      end
    end else if (in_acc[k]) begin
      in_acc[k] = 1'b0;
      last_len[k] = len[k];
      acc_cnt[k]++;
      chk("cs_len", k, len[k], sp(k) + tp(k) + hp(k));
      chk("strobe_first", k, first[k], sp(k) + 1);
      chk("strobe_cnt", k, nstb[k], tp(k));
      chk("strobe_last", k, lastl[k], sp(k) + tp(k));
      chk("addr_data_stable", k, 32'(unstable[k]), 32'd0);
      if (qh[k] == qt[k]) begin
        chk("unexpected_access", k, 32'd1, 32'd0);
      end else begin
        e = expq[k][qh[k] % 128];
        qh[k]++;
        chk("txn", k, 32'({iswe[k], a0[k], iswe[k] ? d0[k] : 8'h00}),
            32'({e.we, e.a, e.we ? e.d : 8'h00}));
        chk("doe", k, 32'(doe0[k]), 32'(e.we));
        if (!e.we) begin
          rdv_exp = 1'b1;
          chk("rd_data", k, 32'(rdd_v[k]), 32'(e.d));
        end
      end
    end
    chk("rd_valid", k, 32'(rdv_v[k]), 32'(rdv_exp));
    if (busy_v[k]) begin
      bcnt[k]++;
      chk("done_while_busy", k, 32'(done_v[k]), 32'd0);
    end else if (pbusy[k]) begin
      chk("busy_len", k, bcnt[k], bexp[k]);
      chk("init_done_rise", k, 32'(done_v[k]), 32'd1);
    end
    pbusy[k] = busy_v[k];
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) mon(k);
    // bus data is only valid on the last strobe cycle of a read
    din_v[0] = (!rd_n_v[0] && in_acc[0] && nstb[0] == tp(0)) ? rd_val : 8'h11;
    din_v[1] = 8'h00;
    din_v[2] = 8'h00;
  end

  task automatic push(input int k, input logic we, input logic [4:0] ad,
                      input logic [7:0] dd);
    txn_t e;
    e.we = we; e.a = ad; e.d = dd;
    expq[k][qt[k] % 128] = e;
    qt[k]++;
  endtask

  task automatic expect_script(input int k, input int n);
    for (int i = 0; i < n; i++) push(k, 1'b1, roms[k][i][12:8], roms[k][i][7:0]);
    bexp[k] = n * (1 + sp(k) + tp(k) + hp(k));
    bcnt[k] = 0;
  endtask

  task automatic pulse_start(input int k);
    @(negedge clk); start_v[k] = 1'b1;
    @(negedge clk); start_v[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k, input int budget);
    int t;
    t = 0;
    while ((busy_v[k] || qh[k] != qt[k] || in_acc[k]) && t < budget) begin
      @(negedge clk); t++;
    end
    @(negedge clk);
    chk("finished", k, 32'((qh[k] == qt[k]) && !busy_v[k]), 32'd1);
  endtask

  task automatic send(input logic we, input logic [4:0] ad, input logic [7:0] dd);
    int t;
    push(0, we, ad, we ? dd : rd_val);
    req_we = we; req_addr = ad; req_wdata = dd; req_valid = 1'b1;
    t = 0;
    #1;
    while (!rdy_v[0] && t < 100) begin @(negedge clk); #1; t++; end
    chk("req_accept", 0, 32'(rdy_v[0]), 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, required finish within 1 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, base;
    for (int i = 0; i < 64; i++) begin
      roms[0][i] = {i == 31, 5'(i), 8'(64 + i)};
      roms[1][i] = {1'b0, 5'(i + 8), 8'(128 + i)};
      roms[2][i] = {1'b0, 5'(i + 16), 8'(192 + i)};
    end
    for (int k = 0; k < 3; k++) begin
      qh[k] = 0; qt[k] = 0; acc_cnt[k] = 0; bcnt[k] = 0; bexp[k] = 0;
      in_acc[k] = 1'b0; pbusy[k] = 1'b0; last_len[k] = 0;
    end
    rst_v = 3'b111; start_v = 3'b000; rd_val = 8'h00;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 5'h00; req_wdata = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_ctl", 0, 32'({cs_n_v[0], rd_n_v[0], wr_n_v[0], doe_v[0],
                           busy_v[0], done_v[0], rdv_v[0]}), 32'h70);
    chk("rst_bus", 0, 32'({a_v[0], dout_v[0], rdd_v[0], ra0}), 32'd0);
    for (int k = 0; k < 3; k++) chk("rst_ready", k, 32'(rdy_v[k]), 32'd1);
    @(negedge clk); #2 rst_v = 3'b000;

    // full 32-entry script on the default instance
    expect_script(0, 32);
    pulse_start(0);
    chk("busy_after_start", 0, 32'(busy_v[0]), 32'd1);
    chk("ready_in_script", 0, 32'(rdy_v[0]), 32'd0);
    wait_idle(0, 400);
    chk("busy_cycles", 0, bcnt[0], 160);
    chk("rom_addr_end", 0, 32'(ra0), 32'd31);
    chk("init_done", 0, 32'(done_v[0]), 32'd1);

    // runtime write then reads
    send(1'b1, 5'h0A, 8'h5C);
    chk("ready_drop", 0, 32'(rdy_v[0]), 32'd0);
    wait_idle(0, 50);
    chk("wr_cs_len", 0, last_len[0], 4);
    rd_val = 8'hA7;
    send(1'b0, 5'h03, 8'h00);
    wait_idle(0, 50);
    chk("rd_data_hold", 0, 32'(rdd_v[0]), 32'hA7);
    rd_val = 8'h3C;
    send(1'b0, 5'h1E, 8'hFF);
    wait_idle(0, 50);

    // back-to-back writes must keep cs_n high for a cycle between
    send(1'b1, 5'h11, 8'h22);
    send(1'b1, 5'h12, 8'h33);
    wait_idle(0, 50);
    chk("b2b_count", 0, acc_cnt[0], 32 + 5);

    // start wins over a simultaneous request; request served after init
    expect_script(0, 32);
    push(0, 1'b1, 5'h1F, 8'h99);
    @(negedge clk);
    start_v[0] = 1'b1;
    req_we = 1'b1; req_addr = 5'h1F; req_wdata = 8'h99; req_valid = 1'b1;
    #1 chk("ready_vs_start", 0, 32'(rdy_v[0]), 32'd0);
    @(negedge clk); start_v[0] = 1'b0;
    t = 0;
    while (!rdy_v[0] && t < 400) begin @(negedge clk); t++; end
    chk("served_after_init", 0, 32'(done_v[0]), 32'd1);
    @(negedge clk); req_valid = 1'b0;
    wait_idle(0, 50);

    // reset in the strobe of script entry 5, then replay
    expect_script(0, 32);
    base = acc_cnt[0];
    pulse_start(0);
    t = 0;
    while (!(acc_cnt[0] == base + 5 && in_acc[0] && !wr_n_v[0]) && t < 200) begin
      @(negedge clk); t++;
    end
    chk("reach_entry5", 0, 32'(t < 200), 32'd1);
    #2 rst_v[0] = 1'b1;
    #1;
    chk("rst_mid_ctl", 0, 32'({cs_n_v[0], wr_n_v[0], doe_v[0],
                               busy_v[0], done_v[0]}), 32'h18);
    qh[0] = qt[0];
    @(negedge clk); #2 rst_v[0] = 1'b0;
    expect_script(0, 32);
    pulse_start(0);
    wait_idle(0, 400);
    chk("replay_rom_addr", 0, 32'(ra0), 32'd31);

    // no last bit: stops at the top address; restart mid-script is ignored
    expect_script(1, 8);
    pulse_start(1);
    repeat (7) @(negedge clk);
    start_v[1] = 1'b1;
    @(negedge clk); start_v[1] = 1'b0;
    wait_idle(1, 200);
    chk("u1_writes", 1, acc_cnt[1], 8);
    chk("u1_rom_addr", 1, 32'(ra1), 32'd7);
    chk("u1_done", 1, 32'(done_v[1]), 32'd1);

    // slow timing: cs_n low 7 cycles per access
    expect_script(2, 8);
    pulse_start(2);
    wait_idle(2, 200);
    chk("u2_cs_len", 2, last_len[2], 7);
    chk("u2_writes", 2, acc_cnt[2], 8);
    chk("u2_busy", 2, bcnt[2], 64);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule

// File: doc/vera_bus_sequencer.md
Name: vera_bus_sequencer

Overview:
- Bus master for the VERA external register bus (5-bit address, 8-bit data, active-low cs/rd/wr).
- Replays a register-init script from a synchronous ROM after `start`, then serves runtime single-register read/write requests through a valid/ready port.
- Generates parameterised setup/strobe/hold timing.
- Sits between the demo top and the `vera` instance, replacing ad-hoc strobe driving in the top.

Parameters:
- ROM_AW, 6, script ROM address width; script depth is 2^ROM_AW entries.
- SETUP_CYC, 1, cycles with cs_n low and address/data valid before the strobe (>=1).
- STROBE_CYC, 2, cycles rd_n or wr_n is held low (>=1).
- HOLD_CYC, 1, cycles cs_n is held low after the strobe ends (>=1).

Ports:
- clk  in  1  system clock (pixel-domain 25 MHz)
- reset  in  1  asynchronous, active-high reset
- start  in  1  1-cycle pulse: run the init script from entry 0
- busy  out  1  high while the script is running
- init_done  out  1  script completed; cleared by reset or an accepted start
- rom_addr  out  ROM_AW  script ROM address (registered)
- rom_data  in  14  ROM word, valid 1 cycle after rom_addr: [13]=last, [12:8]=reg addr, [7:0]=data
- req_valid  in  1  runtime request valid
- req_ready  out  1  runtime request accepted when valid&ready
- req_we  in  1  1=write, 0=read
- req_addr  in  5  register address
- req_wdata  in  8  write data
- rd_valid  out  1  1-cycle pulse: rd_data valid
- rd_data  out  8  read result
- extbus_cs_n  out  1  chip select
- extbus_rd_n  out  1  read strobe
- extbus_wr_n  out  1  write strobe
- extbus_a  out  5  bus address
- extbus_dout  out  8  write data to the bus
- extbus_doe  out  1  data output enable (top drives extbus_d only when high)
- extbus_din  in  8  read data from the bus

Behaviour:
- Reset (async, immediate): cs_n=rd_n=wr_n=1, a=0, dout=0, doe=0, busy=0, init_done=0, rom_addr=0, rd_valid=0, rd_data=0, state=IDLE. Reset mid-access deasserts all strobes at once; no partial access resumes.
- All outputs are registered except req_ready = (state==IDLE) & ~start.
- States: IDLE, FETCH, SETUP, STROBE, HOLD; one down-counter is reloaded on each phase entry.
- IDLE:
  - start=1 has priority over a request: rom_addr<=0, busy<=1, init_done<=0, go to FETCH.
  - start while not IDLE is ignored.
  - Otherwise req_valid&req_ready latches we/addr/wdata and goes to SETUP.
- FETCH (1 cycle): latch rom_data into addr/data, we=1, last flag; go to SETUP.
- SETUP (SETUP_CYC cycles): cs_n=0, a valid; for writes dout valid and doe=1.
- STROBE (STROBE_CYC cycles): wr_n=0 for writes, rd_n=0 for reads. For reads, sample extbus_din on the final strobe cycle.
- HOLD (HOLD_CYC cycles): cs_n=0, strobes=1, a/dout/doe unchanged. On exit, cs_n=1 and doe=0 in the same edge.
  - Read exit: rd_valid=1 for exactly 1 cycle with rd_data.
  - Script entry exit, last=0 and rom_addr != 2^ROM_AW-1: rom_addr+1, go to FETCH.
  - Script entry exit, otherwise: busy=0, init_done=1, go to IDLE.
  - Request exit: go to IDLE.
- Access length: cs_n is low for exactly SETUP_CYC+STROBE_CYC+HOLD_CYC cycles. Back-to-back runtime accesses have at least 1 IDLE cycle with cs_n=1 between them.
- Script entry period is 1+SETUP_CYC+STROBE_CYC+HOLD_CYC cycles (5 with defaults).
- rd_n and wr_n are never low simultaneously. Neither is low while cs_n=1.
- rom_addr does not wrap: the entry at the top address always terminates the script.
- req_ready=0 throughout the script; a held req_valid is served after init_done rises.

Test Plan:
- Reset, then start; ROM entries 0..31 = {last=(i==31), addr=i, data=0x40+i} -> 32 writes in order, addr i/data 0x40+i, each cs_n low 4 cycles, 5-cycle period. busy high 160 cycles, then init_done=1.
- After init, write req (addr 0x0A, data 0x5C) -> req_ready drops next cycle. cs_n low 4 cycles, wr_n low cycles 2-3, doe high only while cs_n low, rd_n stays 1.
- Read req addr 0x03 with extbus_din=0xA7 during the strobe -> rd_n low 2 cycles, rd_valid 1-cycle pulse with rd_data=0xA7, doe=0 throughout.
- start and req_valid asserted in the same IDLE cycle -> request not accepted (req_ready=0), script runs first. Request completes after init_done=1.
- Assert reset during STROBE of script entry 5 -> next sample shows cs_n=wr_n=1, doe=0, busy=0, init_done=0. A new start replays from entry 0.
- ROM with no last bit, ROM_AW=3 -> exactly 8 writes, stops at entry 7, init_done=1. Repeat with SETUP=2/STROBE=3/HOLD=2 -> cs_n low 7 cycles per access.
